magic_nor_engine: RTL and testbench
===================================

MAGIC_NOR_ENGINE -- requirements
Module: magic_nor_engine

Interface
REQ-001 SHALL have parameter NUM_IN, default 10: primary inputs per evaluation, loaded into cells 0..NUM_IN-1.
REQ-002 SHALL have parameter NUM_OUT, default 1: result bits per evaluation.
REQ-003 SHALL have parameter LANES, default 8: input vectors evaluated bit-parallel; every cell is LANES bits wide.
REQ-004 SHALL have parameter CELL_AW, default 8: cell address width; NUM_CELLS = 2**CELL_AW, NUM_CELLS > NUM_IN.
REQ-005 SHALL have parameter PC_W, default 8: program address width; PROG_DEPTH = 2**PC_W.
REQ-006 SHALL have port clk, input, 1: single clock, rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port prog_we, input, 1: program-memory write strobe.
REQ-009 SHALL have port prog_addr, input, PC_W: program write address.
REQ-010 SHALL have port prog_data, input, 2+3*CELL_AW: instruction {op[1:0], dst, a, b}.
REQ-011 SHALL have port in_valid / in_ready, input / output, 1 each: input handshake.
REQ-012 SHALL have port in_data, input, NUM_IN*LANES: bits [i*LANES +: LANES] hold input i for all lanes.
REQ-013 SHALL have port out_valid / out_ready, output / input, 1 each: result handshake.
REQ-014 SHALL have port out_data, output, NUM_OUT*LANES: bits [k*LANES +: LANES] hold result k.
REQ-015 SHALL have port out_err, output, 1: error flag, qualified by out_valid.

Function
REQ-016 SHALL implement states IDLE, EXEC, DONE; in_ready = (state==IDLE).
REQ-017 SHALL, in IDLE on in_valid&&in_ready, write in_data into cells 0..NUM_IN-1, clear out_data and err, set pc=0 and enter EXEC.
REQ-018 SHALL execute exactly one instruction per EXEC cycle, op 00 NOR2: cell[dst] = ~(cell[a] | cell[b]), bitwise across lanes.
REQ-019 SHALL execute op 01 INV as cell[dst] = ~cell[a], with b ignored.
REQ-020 SHALL execute op 10 OUT as out_data slice dst = cell[a]; if dst >= NUM_OUT, no write and err=1.
REQ-021 SHALL execute op 11 HALT by entering DONE.
REQ-022 SHALL read sources as pre-write values when dst equals a or b in the same instruction.
REQ-023 SHALL, in EXEC, increment pc after each non-HALT instruction.
REQ-024 SHALL, if a non-HALT instruction executes at pc = PROG_DEPTH-1, set err=1 and enter DONE (no wrap).
REQ-025 SHALL give latency of N+1 cycles from accepting edge to out_valid high, where N = non-HALT instructions executed.
REQ-026 SHALL hold out_valid=1 in DONE with out_data and out_err stable until out_ready; on out_valid&&out_ready, return to IDLE (in_ready high next cycle).
REQ-027 SHALL perform prog_we writes only in IDLE and ignore them in EXEC/DONE.
REQ-028 SHALL retain cells other than those written, and program memory, across evaluations.

Reset
REQ-029 SHALL, on rst at any state (including mid-EXEC), enter IDLE with pc=0, out_valid=0, out_err=0, out_data=0, in_ready=1 on the next cycle.
REQ-030 SHALL not clear program memory or cell contents on rst; a pending result is discarded.

Verification
REQ-031 SHALL pass: program [NOR2 d=10 a=0 b=1; OUT 0,10; HALT], in_data lane bits x0=8'hF0, x1=8'hCC -> out_data=8'h03 after 3 cycles, out_err=0.
REQ-032 SHALL pass: program [INV 11,2; INV 12,11; OUT 0,12; HALT], x2=8'hA5 -> out_data=8'hA5 after 4 cycles.
REQ-033 SHALL pass: out_ready held low 5 cycles in DONE -> out_valid and out_data stable, in_ready=0, new in_valid not accepted.
REQ-034 SHALL pass: rst asserted at 2nd EXEC cycle -> IDLE next cycle, out_valid=0; re-run of same program gives correct result.
REQ-035 SHALL pass: program all NOR2 with no HALT -> DONE after PROG_DEPTH instructions, out_err=1; separately, OUT with dst=NUM_OUT -> out_err=1.
REQ-036 SHALL pass: prog_we during EXEC overwriting pc+1 -> ignored, result equals unmodified program.

Source files
------------

// File: rtl/magic_nor_engine.sv
// rtl/magic_nor_engine.sv - bit-parallel NOR/INV program engine over a cell array
// Programs are stored once and replayed per input vector set; cells and program survive reset.
module magic_nor_engine #(
    parameter int NUM_IN  = 10,
    parameter int NUM_OUT = 1,
    parameter int LANES   = 8,
    parameter int CELL_AW = 8,
    parameter int PC_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      prog_we,
    input  logic [PC_W-1:0]           prog_addr,
    input  logic [2+3*CELL_AW-1:0]    prog_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_IN*LANES-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_OUT*LANES-1:0]  out_data,
    output logic                      out_err
);
    localparam int IW         = 2 + 3 * CELL_AW;
    localparam int NUM_CELLS  = 2 ** CELL_AW;
    localparam int PROG_DEPTH = 2 ** PC_W;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    typedef enum logic [1:0] {OP_NOR = 2'b00, OP_INV = 2'b01, OP_OUT = 2'b10, OP_HALT = 2'b11} op_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [PC_W-1:0]            r_pc;
    logic [NUM_OUT*LANES-1:0]   r_out;
    logic                       r_err;
    logic [IW-1:0]              r_prog [PROG_DEPTH];
    logic [LANES-1:0]           r_cell [NUM_CELLS];

    logic [IW-1:0]              w_instr;
    op_t                        w_op;
    logic [CELL_AW-1:0]         w_dst;
    logic [CELL_AW-1:0]         w_a;
    logic [CELL_AW-1:0]         w_b;
    logic [LANES-1:0]           w_va;
    logic [LANES-1:0]           w_vb;
    logic                       w_accept;
    logic                       w_exec;
    logic                       w_last;
    logic                       w_cell_we;
    logic [LANES-1:0]           w_cell_wd;
    logic                       w_out_bad;

    assign w_instr   = r_prog[r_pc];
    assign w_op      = op_t'(w_instr[IW-1 -: 2]);
    assign w_dst     = w_instr[3*CELL_AW-1 -: CELL_AW];
    assign w_a       = w_instr[2*CELL_AW-1 -: CELL_AW];
    assign w_b       = w_instr[CELL_AW-1:0];
    // Sources are read combinationally before the write edge, so dst==a/b sees old values.
    assign w_va      = r_cell[w_a];
    assign w_vb      = r_cell[w_b];
    assign w_accept  = in_valid && (r_state == IDLE);
    assign w_exec    = (r_state == EXEC);
    assign w_last    = &r_pc;
    assign w_cell_we = w_exec && ((w_op == OP_NOR) || (w_op == OP_INV));
    assign w_cell_wd = (w_op == OP_INV) ? ~w_va : ~(w_va | w_vb);
    assign w_out_bad = 32'(w_dst) >= NUM_OUT;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_data  = r_out;
    assign out_err   = r_err;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next = EXEC;
            EXEC: if (w_op == OP_HALT || w_last) w_next = DONE;
            DONE: if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc  <= '0;
            r_out <= '0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_pc  <= '0;
            r_out <= '0;
            r_err <= 1'b0;
        end else if (w_exec && w_op != OP_HALT) begin
            if (w_last) r_err <= 1'b1;
            else        r_pc  <= r_pc + 1'b1;
            if (w_op == OP_OUT) begin
                if (w_out_bad) r_err <= 1'b1;
                for (int k = 0; k < NUM_OUT; k++)
                    if (32'(w_dst) == k) r_out[k*LANES +: LANES] <= w_va;
            end
        end
    end

    // Cell and program storage carry no reset so contents persist across evaluations.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_accept) begin
                for (int i = 0; i < NUM_IN; i++)
                    r_cell[i] <= in_data[i*LANES +: LANES];
            end else if (w_cell_we) begin
                r_cell[w_dst] <= w_cell_wd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (prog_we && r_state == IDLE) r_prog[prog_addr] <= prog_data;
    end
endmodule

// File: tb/tb_magic_nor_engine.sv
// tb/tb_magic_nor_engine.sv - directed self-checking bench for magic_nor_engine
module tb_magic_nor_engine;
    logic         clk = 1'b0;
    logic         rst;
    logic         prog_we;
    logic [7:0]   prog_addr;
    logic [25:0]  prog_data;
    logic         in_valid;
    logic         in_ready;
    logic [79:0]  in_data;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_data;
    logic         out_err;

    int errors = 0;
    int checks = 0;
    int lat;
    logic [79:0] din;
    logic [7:0]  held;

    magic_nor_engine dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [25:0] ins(input logic [1:0] op, input logic [7:0] d,
                                        input logic [7:0] a, input logic [7:0] b);
        return {op, d, a, b};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic prog(input int addr, input logic [25:0] w);
        prog_we   = 1'b1;
        prog_addr = addr[7:0];
        prog_data = w;
        step();
        prog_we   = 1'b0;
    endtask

    task automatic start(input logic [79:0] d);
        in_data  = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 2000) begin
            step();
            n++;
        end
    endtask

    task automatic ack();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_err", 32'(out_err), 0);

        // NOR of two inputs
        prog(0, ins(2'b00, 8'd10, 8'd0, 8'd1));
        prog(1, ins(2'b10, 8'd0, 8'd10, 8'd0));
        prog(2, ins(2'b11, 8'd0, 8'd0, 8'd0));
        din = '0; din[0 +: 8] = 8'hF0; din[8 +: 8] = 8'hCC;
        start(din);
        wait_done(lat);
        chk("nor_latency", lat, 3);
        chk("nor_data", 32'(out_data), 32'h03);
        chk("nor_err", 32'(out_err), 0);
        ack();
        chk("nor_ack_in_ready", 32'(in_ready), 1);
        chk("nor_ack_out_valid", 32'(out_valid), 0);

        // dst aliases a: source must be the pre-write value
        prog(0, ins(2'b00, 8'd5, 8'd5, 8'd6));
        prog(1, ins(2'b10, 8'd0, 8'd5, 8'd0));
        prog(2, ins(2'b11, 8'd0, 8'd0, 8'd0));
        din = '0; din[40 +: 8] = 8'h0F; din[48 +: 8] = 8'h30;
        start(din);
        wait_done(lat);
        chk("alias_latency", lat, 3);
        chk("alias_data", 32'(out_data), 32'hC0);
        ack();

        // double inversion through scratch cells
        prog(0, ins(2'b01, 8'd11, 8'd2, 8'd0));
        prog(1, ins(2'b01, 8'd12, 8'd11, 8'd0));
        prog(2, ins(2'b10, 8'd0, 8'd12, 8'd0));
        prog(3, ins(2'b11, 8'd0, 8'd0, 8'd0));
        din = '0; din[16 +: 8] = 8'hA5;
        start(din);
        wait_done(lat);
        chk("inv_latency", lat, 4);
        chk("inv_data", 32'(out_data), 32'hA5);

        // stall in DONE with a competing input offered
        held = 8'hA5;
        in_data = '1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_out_valid", 32'(out_valid), 1);
            chk("stall_out_data", 32'(out_data), 32'(held));
            chk("stall_in_ready", 32'(in_ready), 0);
        end
        in_valid = 1'b0;
        ack();
        chk("stall_release_in_ready", 32'(in_ready), 1);
        chk("stall_release_out_valid", 32'(out_valid), 0);

        // reset during the second EXEC cycle
        din = '0; din[16 +: 8] = 8'h5A;
        start(din);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 1);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_out_data", 32'(out_data), 0);
        chk("midrst_out_err", 32'(out_err), 0);
        start(din);
        wait_done(lat);
        chk("rerun_latency", lat, 4);
        chk("rerun_data", 32'(out_data), 32'h5A);
        ack();

        // program write during EXEC must be ignored
        din = '0; din[16 +: 8] = 8'h3C;
        start(din);
        prog(1, ins(2'b11, 8'd0, 8'd0, 8'd0));
        wait_done(lat);
        chk("progwe_latency", lat, 3);
        chk("progwe_data", 32'(out_data), 32'h3C);
        ack();

        // OUT to a slot beyond NUM_OUT
        prog(0, ins(2'b10, 8'd1, 8'd0, 8'd0));
        prog(1, ins(2'b11, 8'd0, 8'd0, 8'd0));
        din = '0; din[0 +: 8] = 8'hFF;
        start(din);
        wait_done(lat);
        chk("badout_latency", lat, 2);
        chk("badout_err", 32'(out_err), 1);
        chk("badout_data", 32'(out_data), 0);
        ack();

        // full program of NOR2 with no HALT runs off the end
        for (int i = 0; i < 256; i++) prog(i, ins(2'b00, 8'd20, 8'd0, 8'd1));
        din = '0;
        start(din);
        wait_done(lat);
        chk("runoff_latency", lat, 256);
        chk("runoff_err", 32'(out_err), 1);
        chk("runoff_data", 32'(out_data), 0);
        ack();
        chk("runoff_ack_in_ready", 32'(in_ready), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
